// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm trigger block.
package alarm_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam int unsigned N_DIGITS = 6;
  localparam int unsigned TIME_W   = BCD_W * N_DIGITS;

  typedef logic [TIME_W-1:0] bcd_time_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

endpackage

// File: rtl/alarm_trigger_if.sv
// Control/status bundle between the clock front end and the alarm trigger.
interface alarm_trigger_if;
  import alarm_pkg::*;

  logic      tick_1hz;
  bcd_time_t time_bcd;
  bcd_time_t alarm_bcd;
  logic      alarm_en;
  logic      snooze;
  logic      dismiss;
  logic      ringing;
  logic      snoozing;
  logic      buzzer;
  logic [1:0] snooze_cnt;

  modport master (
    output tick_1hz, time_bcd, alarm_bcd, alarm_en, snooze, dismiss,
    input  ringing, snoozing, buzzer, snooze_cnt
  );

  modport slave (
    input  tick_1hz, time_bcd, alarm_bcd, alarm_en, snooze, dismiss,
    output ringing, snoozing, buzzer, snooze_cnt
  );

endinterface

// File: rtl/alarm_match.sv
// Time/alarm comparator producing a one-cycle trigger on the match rising edge.
module alarm_match
  import alarm_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  bcd_time_t time_bcd,
  input  bcd_time_t alarm_bcd,
  input  logic      alarm_en,
  output logic      trigger
);

  logic match;
  logic match_q;
  logic primed;

  assign match = (time_bcd == alarm_bcd);

  // The first sample after reset only loads match_q, so an alarm time that is
  // already showing when reset releases does not count as a fresh match edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q <= 1'b0;
      primed  <= 1'b0;
    end else begin
      match_q <= match;
      primed  <= 1'b1;
    end
  end

  assign trigger = match & ~match_q & alarm_en & primed;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm ringing controller: trigger FSM, snooze/timeout counters, buzzer divider.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_SEC       = 300,
  parameter int unsigned RING_TIMEOUT_SEC = 60,
  parameter int unsigned MAX_SNOOZE       = 3,
  parameter int unsigned BEEP_HALF        = 50000
) (
  input logic            clk,
  input logic            reset_n,
  alarm_trigger_if.slave bus
);

  localparam int unsigned RING_W = (RING_TIMEOUT_SEC > 1) ? $clog2(RING_TIMEOUT_SEC) : 1;
  localparam int unsigned SNZ_W  = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;
  localparam int unsigned DIV_W  = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_SEC - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SEC);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BEEP_HALF - 1);
  localparam logic [1:0]        CNT_MAX   = 2'(MAX_SNOOZE);

  state_t            state, state_n;
  logic [RING_W-1:0] ring_sec, ring_sec_n;
  logic [SNZ_W-1:0]  snz_sec, snz_sec_n;
  logic [1:0]        cnt, cnt_n;
  logic [DIV_W-1:0]  div;
  logic              ringing_r;
  logic              snoozing_r;
  logic              buzzer_r;
  logic              trigger;

  alarm_match u_match (
    .clk       (clk),
    .reset_n   (reset_n),
    .time_bcd  (bus.time_bcd),
    .alarm_bcd (bus.alarm_bcd),
    .alarm_en  (bus.alarm_en),
    .trigger   (trigger)
  );

  // Next-state and counter updates; priority is enable, dismiss, snooze, tick.
  always_comb begin
    state_n    = state;
    ring_sec_n = ring_sec;
    snz_sec_n  = snz_sec;
    cnt_n      = cnt;
    if (!bus.alarm_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_n    = RING;
            cnt_n      = '0;
            ring_sec_n = '0;
          end
        end
        RING: begin
          if (bus.dismiss) begin
            state_n = IDLE;
          end else if (bus.snooze && (cnt < CNT_MAX)) begin
            state_n   = SNOOZE;
            cnt_n     = cnt + 2'd1;
            snz_sec_n = SNZ_LOAD;
          end else if (bus.tick_1hz) begin
            if (ring_sec == RING_LAST) begin
              state_n = IDLE;
            end else begin
              ring_sec_n = ring_sec + RING_W'(1);
            end
          end
        end
        SNOOZE: begin
          if (bus.dismiss) begin
            state_n = IDLE;
          end else if (bus.tick_1hz) begin
            if (snz_sec <= SNZ_W'(1)) begin
              state_n    = RING;
              ring_sec_n = '0;
              snz_sec_n  = '0;
            end else begin
              snz_sec_n = snz_sec - SNZ_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, counters and the registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ring_sec   <= '0;
      snz_sec    <= '0;
      cnt        <= '0;
      ringing_r  <= 1'b0;
      snoozing_r <= 1'b0;
    end else begin
      state      <= state_n;
      ring_sec   <= ring_sec_n;
      snz_sec    <= snz_sec_n;
      cnt        <= cnt_n;
      ringing_r  <= (state_n == RING);
      snoozing_r <= (state_n == SNOOZE);
    end
  end

  // Buzzer divider: cleared on entry to and exit from RING, so the tone always
  // starts with a fresh high phase one cycle after ringing asserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div      <= '0;
      buzzer_r <= 1'b0;
    end else if ((state == RING) && (state_n == RING)) begin
      if (div == '0) begin
        buzzer_r <= ~buzzer_r;
      end
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end else begin
      div      <= '0;
      buzzer_r <= 1'b0;
    end
  end

  assign bus.ringing    = ringing_r;
  assign bus.snoozing   = snoozing_r;
  assign bus.buzzer     = buzzer_r;
  assign bus.snooze_cnt = cnt;

endmodule

// File: tb/tb_alarm_trigger.sv
// Self-checking bench for alarm_trigger (small parameters for short runs).
module tb_alarm_trigger;

  localparam logic [23:0] T0 = 24'h072959;
  localparam logic [23:0] T1 = 24'h073000;

  typedef struct {
    logic        tick, snz, dis, en;
    logic [23:0] tm;
    logic        ring, snzg;
    logic [1:0]  cnt;
    logic        bz_chk, bz;
  } vec_t;

  typedef struct {
    int         id;
    logic       ring, snzg;
    logic [1:0] cnt;
    logic       bz_chk, bz;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset_n;
  int     checks = 0;
  int     errors = 0;
  vec_t   vecs[$];
  exp_t   sb[$];
  exp_t   cur;

  alarm_trigger_if bus ();

  alarm_trigger #(
    .SNOOZE_SEC       (3),
    .RING_TIMEOUT_SEC (5),
    .MAX_SNOOZE       (2),
    .BEEP_HALF        (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_out(input int id, input logic ring, input logic snzg,
                           input logic [1:0] cnt, input logic bz_chk, input logic bz);
    checks++;
    if (bus.ringing !== ring) begin
      errors++;
      $display("FAIL step%0d ringing got %0b want %0b", id, bus.ringing, ring);
    end
    checks++;
    if (bus.snoozing !== snzg) begin
      errors++;
      $display("FAIL step%0d snoozing got %0b want %0b", id, bus.snoozing, snzg);
    end
    checks++;
    if (bus.snooze_cnt !== cnt) begin
      errors++;
      $display("FAIL step%0d snooze_cnt got %0d want %0d", id, bus.snooze_cnt, cnt);
    end
    if (bz_chk) begin
      checks++;
      if (bus.buzzer !== bz) begin
        errors++;
        $display("FAIL step%0d buzzer got %0b want %0b", id, bus.buzzer, bz);
      end
    end
  endtask

  task automatic drive(input logic tick, input logic snz, input logic dis,
                       input logic en, input logic [23:0] tm);
    bus.tick_1hz = tick;
    bus.snooze   = snz;
    bus.dismiss  = dis;
    bus.alarm_en = en;
    bus.time_bcd = tm;
  endtask

  task automatic add(input logic tick, input logic snz, input logic dis, input logic en,
                     input logic [23:0] tm, input logic ring, input logic snzg,
                     input logic [1:0] cnt, input logic bz_chk, input logic bz);
    vec_t v;
    v.tick = tick; v.snz = snz; v.dis = dis; v.en = en; v.tm = tm;
    v.ring = ring; v.snzg = snzg; v.cnt = cnt; v.bz_chk = bz_chk; v.bz = bz;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input int id, input logic ring, input logic snzg,
                          input logic [1:0] cnt, input logic bz_chk, input logic bz);
    exp_t e;
    e.id = id; e.ring = ring; e.snzg = snzg; e.cnt = cnt; e.bz_chk = bz_chk; e.bz = bz;
    sb.push_back(e);
  endtask

  // Scoreboard: each expectation applies to the first rising edge after it was queued.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check_out(cur.id, cur.ring, cur.snzg, cur.cnt, cur.bz_chk, cur.bz);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // tick snz dis en tm | ring snzg cnt bzchk bz
    add(0,0,0,1,T0, 0,0,0,1,0);                                  // 0 idle
    add(0,0,0,1,T1, 1,0,0,1,0);                                  // 1 trigger
    for (int i = 0; i < 4; i++) add(0,0,0,1,T1, 1,0,0,1,1);      // 2-5 high phase
    for (int i = 0; i < 4; i++) add(0,0,0,1,T1, 1,0,0,1,0);      // 6-9 low phase
    add(0,0,0,1,T1, 1,0,0,1,1);                                  // 10 high again
    for (int i = 0; i < 4; i++) add(1,0,0,1,T1, 1,0,0,0,0);      // 11-14 ticks 1..4
    add(1,0,0,1,T1, 0,0,0,1,0);                                  // 15 5th tick timeout
    add(0,0,0,1,T1, 0,0,0,1,0);                                  // 16
    add(1,0,0,1,T1, 0,0,0,1,0);                                  // 17 6th tick, no re-ring
    add(0,0,0,1,T0, 0,0,0,1,0);                                  // 18
    add(0,0,0,1,T1, 1,0,0,1,0);                                  // 19 trigger
    add(0,1,0,1,T1, 0,1,1,1,0);                                  // 20 snooze 1
    add(1,0,0,1,T1, 0,1,1,1,0);                                  // 21
    add(1,0,0,1,T1, 0,1,1,0,0);                                  // 22
    add(1,0,0,1,T1, 1,0,1,1,0);                                  // 23 re-ring
    add(0,0,0,1,T1, 1,0,1,1,1);                                  // 24 buzzer restarts
    add(0,1,0,1,T1, 0,1,2,1,0);                                  // 25 snooze 2
    add(1,0,0,1,T1, 0,1,2,0,0);                                  // 26
    add(1,1,0,1,T1, 0,1,2,0,0);                                  // 27 snooze in SNOOZE ignored
    add(1,0,0,1,T1, 1,0,2,1,0);                                  // 28 re-ring
    add(0,1,0,1,T1, 1,0,2,1,1);                                  // 29 3rd snooze ignored
    add(0,0,0,1,T1, 1,0,2,0,0);                                  // 30
    add(0,0,1,1,T1, 0,0,2,1,0);                                  // 31 dismiss, cnt held
    add(0,0,0,1,T1, 0,0,2,1,0);                                  // 32
    add(0,0,0,1,T0, 0,0,2,0,0);                                  // 33
    add(0,0,0,1,T1, 1,0,0,1,0);                                  // 34 trigger clears cnt
    add(0,1,1,1,T1, 0,0,0,1,0);                                  // 35 dismiss beats snooze
    add(0,0,0,1,T0, 0,0,0,0,0);                                  // 36
    add(0,0,0,1,T1, 1,0,0,0,0);                                  // 37 trigger
    add(0,1,0,1,T1, 0,1,1,0,0);                                  // 38 snooze
    add(0,0,0,0,T1, 0,0,1,1,0);                                  // 39 enable drop
    for (int i = 0; i < 4; i++) add(1,0,0,1,T1, 0,0,1,0,0);      // 40-43 no re-ring
    add(0,0,0,0,T0, 0,0,1,0,0);                                  // 44
    add(0,0,0,0,T1, 0,0,1,0,0);                                  // 45 match edge while disarmed
    add(0,0,0,1,T1, 0,0,1,0,0);                                  // 46 edge already passed
    add(0,0,0,1,T0, 0,0,1,0,0);                                  // 47
    add(0,0,0,1,T1, 1,0,0,1,0);                                  // 48 trigger
    add(0,0,0,1,T1, 1,0,0,1,1);                                  // 49 buzzer high

    reset_n       = 1'b0;
    bus.alarm_bcd = T1;
    drive(0, 0, 0, 1, T0);
    repeat (2) @(negedge clk);
    check_out(-1, 0, 0, 2'd0, 1, 0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].tick, vecs[i].snz, vecs[i].dis, vecs[i].en, vecs[i].tm);
      push_exp(i, vecs[i].ring, vecs[i].snzg, vecs[i].cnt, vecs[i].bz_chk, vecs[i].bz);
    end

    // Asynchronous reset while ringing, then release with the alarm time still showing.
    @(posedge clk);
    #3;
    drive(0, 0, 0, 1, T1);
    reset_n = 1'b0;
    #1;
    check_out(100, 0, 0, 2'd0, 1, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, T1);
      push_exp(101 + i, 0, 0, 2'd0, 1, 0);
    end
    @(negedge clk); drive(0, 0, 0, 1, T0); push_exp(104, 0, 0, 2'd0, 1, 0);
    @(negedge clk); drive(0, 0, 0, 1, T1); push_exp(105, 1, 0, 2'd0, 1, 0);
    @(negedge clk); drive(0, 0, 0, 1, T1); push_exp(106, 1, 0, 2'd0, 1, 1);
    @(negedge clk); drive(0, 0, 1, 1, T1); push_exp(107, 0, 0, 2'd0, 1, 0);
    @(negedge clk); drive(0, 0, 0, 1, T1);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
